// File: rtl/exec_seq_ctrl.sv
// Multi-cycle FETCH/WAIT_I/DECODE/READ/EXEC/WB sequencer for the single-issue core.
// Optional perf counters (cycle_cnt, stall_cnt) are built only when SEQ_PERF_CNT_EN is defined.
module exec_seq_ctrl #(
  parameter int          ALU_TIMEOUT = 16,
  parameter logic [31:0] HALT_INSTR  = 32'h0000_0073,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop_req,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             wb_req,
  input  logic             alu_data_valid,
  output logic             next_instr,
  output logic             dec_en,
  output logic             rs_addr_valid,
  output logic             alu_start,
  output logic             rd_wr_en,
  output logic             op_done,
  output logic             busy,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int             TMR_W    = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_I, S_DECODE, S_READ, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic             wb_q;
  logic             stop_pend_q;
  logic             next_instr_q, dec_en_q, rs_addr_valid_q, alu_start_q;
  logic             rd_wr_en_q, op_done_q, busy_q, halted_q, err_timeout_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             in_busy;
  logic             timeout_hit;

  assign in_busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign timeout_hit = (state_q == S_EXEC) && !alu_data_valid && (tmr_q == TMR_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT_I;
      S_WAIT_I: if (instr_valid) state_d = (instr == HALT_INSTR) ? S_HALT : S_DECODE;
      S_DECODE: state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      // A result arriving on the terminal count still retires the instruction.
      S_EXEC: begin
        if (alu_data_valid)   state_d = S_WB;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB:     state_d = (stop_pend_q || stop_req) ? S_IDLE : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      tmr_q           <= '0;
      wb_q            <= 1'b0;
      stop_pend_q     <= 1'b0;
      next_instr_q    <= 1'b0;
      dec_en_q        <= 1'b0;
      rs_addr_valid_q <= 1'b0;
      alu_start_q     <= 1'b0;
      rd_wr_en_q      <= 1'b0;
      op_done_q       <= 1'b0;
      busy_q          <= 1'b0;
      halted_q        <= 1'b0;
      err_timeout_q   <= 1'b0;
      instr_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      tmr_q           <= (state_q == S_EXEC && state_d == S_EXEC) ? tmr_q + TMR_W'(1) : '0;
      if (state_q == S_DECODE) wb_q <= wb_req;
      if (state_q == S_WB)             stop_pend_q <= 1'b0;
      else if (in_busy && stop_req)    stop_pend_q <= 1'b1;
      next_instr_q    <= (state_d == S_FETCH);
      dec_en_q        <= (state_d == S_DECODE);
      rs_addr_valid_q <= (state_d == S_READ);
      alu_start_q     <= (state_d == S_EXEC) && (state_q != S_EXEC);
      rd_wr_en_q      <= (state_d == S_WB) && wb_q;
      op_done_q       <= (state_d == S_WB);
      busy_q          <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q        <= (state_d == S_HALT);
      if (timeout_hit) err_timeout_q <= 1'b1;
      if (state_d == S_WB) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign next_instr    = next_instr_q;
  assign dec_en        = dec_en_q;
  assign rs_addr_valid = rs_addr_valid_q;
  assign alu_start     = alu_start_q;
  assign rd_wr_en      = rd_wr_en_q;
  assign op_done       = op_done_q;
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign err_timeout   = err_timeout_q;
  assign instr_cnt     = instr_cnt_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall;

  assign stall = ((state_q == S_WAIT_I) && !instr_valid) ||
                 ((state_q == S_EXEC) && !alu_data_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (in_busy) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (stall)   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
